// File: rtl/cic3_row_readout_ctrl.sv
// cic3_row_readout_ctrl: readout scheduler for a 2x12 row of CIC3 decimation filters.
// It drives the left/right monitor selects and generates decimation-frame timing.
// After each select change it discards settle frames, then snapshots the row and
// serializes it LSB first over a valid/ready stream.
// Optional feature: define MONITOR_SWEEP_EN to step both selects through every test point.
module cic3_row_readout_ctrl #(
  parameter int NUM_FILTERS   = 24,
  parameter int DECIM         = 32,
  parameter int SETTLE_FRAMES = 2,
  parameter int NUM_TP        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3:0]             sel_cfg_L,
  input  logic [3:0]             sel_cfg_R,
  input  logic [NUM_FILTERS-1:0] row_out,
  output logic [3:0]             digital_monitor_selL,
  output logic [3:0]             digital_monitor_selR,
  output logic                   frame_strobe,
  output logic                   dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_last,
  output logic                   overrun,
  output logic                   busy
);

  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int SET_W = $clog2(SETTLE_FRAMES + 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FILTERS - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_FRAMES - 1);
  localparam logic [3:0]       TP_LAST  = 4'(NUM_TP - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2, SHIFT = 2'd3} state_t;

  state_t                 state, state_nxt;
  logic [DEC_W-1:0]       dec_cnt;
  logic [SET_W-1:0]       settle_cnt;
  logic [IDX_W-1:0]       idx;
  logic [NUM_FILTERS-1:0] shadow;
  logic                   pend;
  logic                   xfer, last_xfer, sel_chg, settle_req, sweep_step;
  logic [3:0]             load_val_l, load_val_r;
  logic                   load_sel, step_sel, capture, settle_clr, settle_inc, pend_set, ovr_set;

`ifdef MONITOR_SWEEP_EN
  // Sweep mode: static configuration is ignored, every completed frame re-settles.
  logic unused_sweep_inputs;
  assign unused_sweep_inputs = ^{sel_cfg_L, sel_cfg_R, pend};
  assign sel_chg    = 1'b0;
  assign settle_req = 1'b1;
  assign sweep_step = 1'b1;
  assign load_val_l = 4'd0;
  assign load_val_r = 4'd0;
`else
  // A differing configuration is only acted on at frame boundaries.
  assign sel_chg    = (sel_cfg_L != digital_monitor_selL) || (sel_cfg_R != digital_monitor_selR);
  assign settle_req = pend || (frame_strobe && sel_chg);
  assign sweep_step = 1'b0;
  assign load_val_l = sel_cfg_L;
  assign load_val_r = sel_cfg_R;
`endif

  assign xfer      = dout_valid & dout_ready;
  assign last_xfer = xfer & dout_last;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt  = state;
    load_sel   = 1'b0;
    step_sel   = 1'b0;
    capture    = 1'b0;
    settle_clr = 1'b0;
    settle_inc = 1'b0;
    pend_set   = 1'b0;
    ovr_set    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt  = SETTLE;
          load_sel   = 1'b1;
          settle_clr = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (frame_strobe) begin
          if (settle_cnt == SET_LAST) begin
            state_nxt = RUN;
          end else begin
            settle_inc = 1'b1;
          end
        end else begin
          state_nxt = SETTLE;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (frame_strobe) begin
          if (sel_chg) begin
            state_nxt  = SETTLE;
            load_sel   = 1'b1;
            settle_clr = 1'b1;
          end else begin
            state_nxt = SHIFT;
            capture   = 1'b1;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      SHIFT: begin
        // New selects are latched at the boundary; the frame in flight still finishes.
        if (frame_strobe && sel_chg) begin
          load_sel = 1'b1;
          pend_set = 1'b1;
        end else begin
          load_sel = 1'b0;
        end
        if (frame_strobe && !last_xfer && enable) begin
          ovr_set = 1'b1;
        end else begin
          ovr_set = 1'b0;
        end
        if (last_xfer) begin
          if (!enable) begin
            state_nxt = IDLE;
          end else if (settle_req) begin
            state_nxt  = SETTLE;
            settle_clr = 1'b1;
            step_sel   = sweep_step;
          end else if (frame_strobe) begin
            state_nxt = SHIFT;
            capture   = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          state_nxt = SHIFT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stream outputs and frame boundary decode from registered state
  always_comb begin
    frame_strobe = (dec_cnt == DEC_LAST);
    if (state == SHIFT) begin
      dout_valid = 1'b1;
      dout       = shadow[idx];
      dout_last  = (idx == IDX_LAST);
    end else begin
      dout_valid = 1'b0;
      dout       = 1'b0;
      dout_last  = 1'b0;
    end
  end

  // Counters, shadow register, selects and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_cnt              <= '0;
      settle_cnt           <= '0;
      idx                  <= '0;
      shadow               <= '0;
      pend                 <= 1'b0;
      digital_monitor_selL <= 4'd0;
      digital_monitor_selR <= 4'd0;
      overrun              <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      if ((state == IDLE) || (state_nxt == IDLE)) begin
        dec_cnt <= '0;
      end else if (dec_cnt == DEC_LAST) begin
        dec_cnt <= '0;
      end else begin
        dec_cnt <= dec_cnt + DEC_W'(1);
      end
      if (settle_clr) begin
        settle_cnt <= '0;
      end else if (settle_inc) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end else begin
        settle_cnt <= settle_cnt;
      end
      if (capture) begin
        shadow <= row_out;
        idx    <= '0;
      end else if (last_xfer) begin
        idx <= '0;
      end else if (xfer) begin
        idx <= idx + IDX_W'(1);
      end else begin
        idx <= idx;
      end
      if (state_nxt != SHIFT) begin
        pend <= 1'b0;
      end else if (pend_set) begin
        pend <= 1'b1;
      end else begin
        pend <= pend;
      end
      if (load_sel) begin
        digital_monitor_selL <= load_val_l;
        digital_monitor_selR <= load_val_r;
      end else if (step_sel) begin
        digital_monitor_selL <= (digital_monitor_selL == TP_LAST) ? 4'd0 : digital_monitor_selL + 4'd1;
        digital_monitor_selR <= (digital_monitor_selR == TP_LAST) ? 4'd0 : digital_monitor_selR + 4'd1;
      end else begin
        digital_monitor_selL <= digital_monitor_selL;
        digital_monitor_selR <= digital_monitor_selR;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
      busy <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_cic3_row_readout_ctrl.sv
// Self-checking bench for cic3_row_readout_ctrl: directed scenarios with random row data
// and ready patterns, compared every cycle against a frame-level reference model.
module tb_cic3_row_readout_ctrl;
  localparam int NF    = 24;
  localparam int DECIM = 32;
  localparam int SF    = 2;
  localparam int NTP   = 16;
`ifdef MONITOR_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable, dout_ready;
  logic [3:0]    sel_cfg_L, sel_cfg_R;
  logic [NF-1:0] row_out;
  logic [3:0]    selL, selR;
  logic          frame_strobe, dout, dout_valid, dout_last, overrun, busy;

  int errors = 0;
  int checks = 0;

  // reference model state
  int            e, e_enter, settle_left, bits_left, first_valid;
  bit            m_run, m_ovr, m_pend, rand_row;
  logic [NF-1:0] m_frame;
  logic [3:0]    m_sel_l, m_sel_r;

  always #5 clk = ~clk;

  cic3_row_readout_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sel_cfg_L(sel_cfg_L), .sel_cfg_R(sel_cfg_R), .row_out(row_out),
    .digital_monitor_selL(selL), .digital_monitor_selR(selR),
    .frame_strobe(frame_strobe), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .overrun(overrun), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT is about to sample.
  task automatic model_step();
    bit st, xf, last, chg;
    st   = m_run && (((e - e_enter) % DECIM) == DECIM - 1);
    xf   = (bits_left > 0) && (dout_ready == 1'b1);
    last = xf && (bits_left == 1);
    chg  = !SWEEP && ((sel_cfg_L != m_sel_l) || (sel_cfg_R != m_sel_r));
    if (!m_run) begin
      if (enable) begin
        m_run = 1'b1; e_enter = e + 1; settle_left = SF; m_pend = 1'b0;
        m_sel_l = SWEEP ? 4'd0 : sel_cfg_L;
        m_sel_r = SWEEP ? 4'd0 : sel_cfg_R;
      end
    end else if (bits_left > 0) begin
      if (st && chg) begin
        m_sel_l = sel_cfg_L; m_sel_r = sel_cfg_R; m_pend = 1'b1;
      end
      if (st && !last && enable) m_ovr = 1'b1;
      if (xf) bits_left--;
      if (last) begin
        if (!enable) m_run = 1'b0;
        else if (SWEEP) begin
          m_sel_l = 4'((m_sel_l + 1) % NTP);
          m_sel_r = 4'((m_sel_r + 1) % NTP);
          settle_left = SF;
        end else if (m_pend) begin
          settle_left = SF; m_pend = 1'b0;
        end else if (st) begin
          m_frame = row_out; bits_left = NF;
        end
      end
    end else if (!enable) begin
      m_run = 1'b0;
    end else if (settle_left > 0) begin
      if (st) settle_left--;
    end else if (st) begin
      if (chg) begin
        m_sel_l = sel_cfg_L; m_sel_r = sel_cfg_R; settle_left = SF;
      end else begin
        m_frame = row_out; bits_left = NF;
      end
    end
  endtask

  task automatic tick();
    logic exp_dout, exp_last;
    model_step();
    @(posedge clk);
    #1;
    e++;
    exp_dout = (bits_left > 0) ? m_frame[NF - bits_left] : 1'b0;
    exp_last = (bits_left == 1);
    chk("busy", 32'(busy), 32'(m_run));
    chk("dout_valid", 32'(dout_valid), 32'(bits_left > 0));
    chk("dout", 32'(dout), 32'(exp_dout));
    chk("dout_last", 32'(dout_last), 32'(exp_last));
    chk("frame_strobe", 32'(frame_strobe),
        32'(m_run && (((e - e_enter) % DECIM) == DECIM - 1)));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("selL", 32'(selL), 32'(m_sel_l));
    chk("selR", 32'(selR), 32'(m_sel_r));
    if (dout_valid && first_valid < 0) first_valid = e;
    if (rand_row) row_out = NF'($urandom);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("reset_outputs_async", 32'({selL, selR, frame_strobe, dout, dout_valid, dout_last, overrun, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_held", 32'({selL, selR, frame_strobe, dout, dout_valid, dout_last, overrun, busy}), 32'd0);
    m_run = 1'b0; m_ovr = 1'b0; m_pend = 1'b0; bits_left = 0; settle_left = 0;
    m_sel_l = 4'd0; m_sel_r = 4'd0; e = 0; e_enter = 0; first_valid = -1;
    reset = 1'b0;
  endtask

  initial begin
    int base;
    enable = 1'b1; dout_ready = 1'b1; sel_cfg_L = 4'd3; sel_cfg_R = 4'd5;
    row_out = NF'($urandom); rand_row = 1'b1; m_frame = '0;

    // S1: first frame latency, then static pattern for four frames
    do_reset();
    for (int k = 0; k < 120 && first_valid < 0; k++) tick();
    chk("first_valid_edge", 32'(first_valid), 32'd97);
    rand_row = 1'b0; row_out = 24'hA5A5A5;
    repeat (4 * DECIM + 32) tick();
    chk("no_overrun_ready_high", 32'(overrun), 32'd0);

    // S2: long ready stall in SHIFT drops a frame and sets sticky overrun
    rand_row = 1'b1;
    for (int k = 0; k < 100 && bits_left != NF - 5; k++) tick();
    chk("wait_stall_point", 32'(bits_left == NF - 5), 32'd1);
    dout_ready = 1'b0;
    repeat (40) tick();
    dout_ready = 1'b1;
    chk("overrun_set", 32'(overrun), 32'd1);
    repeat (100) tick();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // S3: stalls placed so the last transfer lands on the frame boundary
    do_reset();
    for (int k = 0; k < 120 && first_valid < 0; k++) tick();
    chk("first_valid_s3", 32'(first_valid), 32'd97);
    for (int f = 0; f < 3; f++) begin
      dout_ready = 1'b0;
      repeat (DECIM - NF) tick();
      dout_ready = 1'b1;
      repeat (NF) tick();
      chk("back_to_back_valid", 32'(dout_valid), 32'd1);
    end
    chk("no_overrun_coincide", 32'(overrun), 32'd0);

    // S4: random ready pattern against the model
    for (int k = 0; k < 400; k++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    dout_ready = 1'b1;

    // S5: enable dropped at bit 10 of a frame
    do_reset();
    for (int k = 0; k < 120 && first_valid < 0; k++) tick();
    for (int k = 0; k < 40 && bits_left != NF - 10; k++) tick();
    chk("wait_bit10", 32'(bits_left == NF - 10), 32'd1);
    enable = 1'b0;
    repeat (NF - 10) tick();
    chk("idle_after_drain", 32'(busy), 32'd0);
    tick();
    base = e; first_valid = -1; enable = 1'b1;
    for (int k = 0; k < 120 && first_valid < 0; k++) tick();
    chk("relaunch_latency", 32'(first_valid - base), 32'd97);

    // S6: enable dropped during SETTLE
    enable = 1'b0;
    repeat (30) tick();
    enable = 1'b1;
    repeat (40) tick();
    enable = 1'b0;
    tick();
    chk("settle_abort_idle", 32'(busy), 32'd0);
    repeat (50) tick();

    // S7: select change while running (sweep build: long sweep run)
    enable = 1'b1; first_valid = -1;
    for (int k = 0; k < 120 && first_valid < 0; k++) tick();
    chk("first_valid_s7", 32'(first_valid > 0), 32'd1);
`ifdef MONITOR_SWEEP_EN
    repeat (17 * 3 * DECIM + 200) tick();
`else
    sel_cfg_L = 4'd7;
    repeat (200) tick();
    chk("selL_changed", 32'(selL), 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
